// File: rtl/cmd_responder.sv
// ============================================================================
// cmd_responder
// ----------------------------------------------------------------------------
// Far end of the request/response FIFO pair. Pops request bytes from the
// request FIFO, parses framed commands (PING / READ / WRITE on a small 8-bit
// register file) and pushes framed responses into the response FIFO.
//
// Request frame : A5, CMD, LEN, LEN payload bytes, CHK = XOR(CMD, LEN, payload)
// Response frame: 5A, RCMD, RLEN, RLEN bytes, RCHK = XOR(RCMD, RLEN, data)
//
// Ports
//   clk                  system clock
//   rst                  asynchronous reset, active-high
//   req_fifo_empty       request FIFO empty
//   req_fifo_r_en        one-cycle read pulse to the request FIFO
//   req_fifo_data_o      request byte (valid one cycle after r_en)
//   req_fifo_data_o_vld  request byte valid
//   rsp_fifo_data_i      response byte
//   rsp_fifo_data_i_vld  response byte valid
//   rsp_fifo_data_i_rdy  response FIFO accepts the byte this cycle
//   reg_o                flat register file, reg[k] = reg_o[8k+7:8k]
//   busy                 FSM is outside HUNT
//   frame_cnt            good frames executed (saturating)
//   err_cnt              errored / timed-out frames (saturating)
//   dbgState             current FSM state encoding
//
// Response handshake: rsp_fifo_data_i_vld is held high with
// rsp_fifo_data_i stable until a cycle in which rsp_fifo_data_i_rdy is also
// high; that cycle transfers the byte and the next byte (if any) may be
// presented in the following cycle.
// ============================================================================
module cmd_responder #(
    parameter int REG_ADDR_W     = 3,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_fifo_empty,
    output logic                         req_fifo_r_en,
    input  logic [7:0]                   req_fifo_data_o,
    input  logic                         req_fifo_data_o_vld,
    output logic [7:0]                   rsp_fifo_data_i,
    output logic                         rsp_fifo_data_i_vld,
    input  logic                         rsp_fifo_data_i_rdy,
    output logic [8*(2**REG_ADDR_W)-1:0] reg_o,
    output logic                         busy,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  err_cnt,
    output logic [2:0]                   dbgState
);

    localparam int          NUM_REGS  = 2**REG_ADDR_W;
    localparam bit          TO_ENABLE = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    localparam logic [7:0] REQ_SYNC = 8'hA5;
    localparam logic [7:0] RSP_SYNC = 8'h5A;
    localparam logic [7:0] CMD_PING  = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        EXEC    = 3'd5,
        SEND    = 3'd6
    } stateT;

    stateT state, nextState;

    // Byte fetch
    logic       rdPending;
    logic       byteCap;
    logic [7:0] byteIn;
    logic       inFrame;
    logic       needByte;

    // Frame parsing
    logic [7:0] cmdReg;
    logic [7:0] lenReg;
    logic [7:0] payCnt;
    logic [7:0] pay0;
    logic [7:0] pay1;
    logic [7:0] chkAcc;
    logic       chkBad;

    // Timeout
    logic [31:0] idleCnt;
    logic        timeoutHit;

    // Decode
    logic       isPing, isRead, isWrite;
    logic       lenBad, addrBad;
    logic [7:0] errCode;
    logic [7:0] rdData;

    // Response
    logic [7:0] rspBuf [5];
    logic [2:0] sendIdx;
    logic [2:0] sendLast;
    logic       sendDone;

    logic [7:0] regFile [NUM_REGS];

    // ------------------------------------------------------------------
    // Byte fetch: at most one read outstanding. A read whose data comes
    // back without vld is simply dropped; the next cycle refetches.
    // ------------------------------------------------------------------
    assign inFrame  = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign needByte = inFrame || (state == HUNT);
    assign byteIn   = req_fifo_data_o;
    assign byteCap  = rdPending && req_fifo_data_o_vld;

    assign req_fifo_r_en = needByte && !req_fifo_empty && !rdPending;

    // A byte captured this cycle always wins over an expiring timeout.
    assign timeoutHit = TO_ENABLE && inFrame && !byteCap && (idleCnt == TO_LAST);

    assign sendDone = (state == SEND) && rsp_fifo_data_i_rdy && (sendIdx == sendLast);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            HUNT: begin
                if (byteCap && (byteIn == REQ_SYNC)) nextState = CMD;
            end
            CMD: begin
                if (byteCap)         nextState = LEN;
                else if (timeoutHit) nextState = HUNT;
            end
            LEN: begin
                if (byteCap)         nextState = (byteIn == 8'd0) ? CHK : PAYLOAD;
                else if (timeoutHit) nextState = HUNT;
            end
            PAYLOAD: begin
                // lenReg is at least 1 here, so lenReg - 1 is the last index.
                if (byteCap && (payCnt == lenReg - 8'd1)) nextState = CHK;
                else if (timeoutHit)                      nextState = HUNT;
            end
            CHK: begin
                if (byteCap)         nextState = EXEC;
                else if (timeoutHit) nextState = HUNT;
            end
            EXEC: begin
                nextState = SEND;
            end
            SEND: begin
                if (sendDone) nextState = HUNT;
            end
            default: begin
                nextState = HUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command decode and error classification (used in EXEC)
    // ------------------------------------------------------------------
    always_comb begin
        isPing  = (cmdReg == CMD_PING);
        isRead  = (cmdReg == CMD_READ);
        isWrite = (cmdReg == CMD_WRITE);
        lenBad  = (isPing  && (lenReg != 8'd0)) ||
                  (isRead  && (lenReg != 8'd1)) ||
                  (isWrite && (lenReg != 8'd2));
        // Any address bit above the register-file index makes it out of range.
        addrBad = (isRead || isWrite) && ((pay0 >> REG_ADDR_W) != 8'd0);
        errCode = 8'h00;
        if (chkBad)                          errCode = 8'h01;
        else if (!(isPing || isRead || isWrite)) errCode = 8'h02;
        else if (lenBad)                     errCode = 8'h03;
        else if (addrBad)                    errCode = 8'h04;
    end

    assign rdData = regFile[pay0[REG_ADDR_W-1:0]];

    // ------------------------------------------------------------------
    // Datapath: fetch tracking, parsing, timeout, execution, send index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPending <= 1'b0;
            cmdReg    <= 8'h00;
            lenReg    <= 8'h00;
            payCnt    <= 8'h00;
            pay0      <= 8'h00;
            pay1      <= 8'h00;
            chkAcc    <= 8'h00;
            chkBad    <= 1'b0;
            idleCnt   <= 32'd0;
            sendIdx   <= 3'd0;
            sendLast  <= 3'd0;
            frame_cnt <= 16'h0000;
            err_cnt   <= 16'h0000;
            for (int i = 0; i < 5; i++) begin
                rspBuf[i] <= 8'h00;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= 8'h00;
            end
        end else begin
            rdPending <= req_fifo_r_en;

            if (!inFrame || byteCap || timeoutHit) begin
                idleCnt <= 32'd0;
            end else begin
                idleCnt <= idleCnt + 32'd1;
            end

            if (timeoutHit && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (byteCap) begin
                case (state)
                    CMD: begin
                        cmdReg <= byteIn;
                        chkAcc <= byteIn;
                    end
                    LEN: begin
                        lenReg <= byteIn;
                        chkAcc <= chkAcc ^ byteIn;
                        payCnt <= 8'h00;
                        pay0   <= 8'h00;
                        pay1   <= 8'h00;
                    end
                    PAYLOAD: begin
                        // Every payload byte feeds the checksum; only the
                        // first two can be meaningful for any command.
                        if (payCnt == 8'd0) pay0 <= byteIn;
                        if (payCnt == 8'd1) pay1 <= byteIn;
                        chkAcc <= chkAcc ^ byteIn;
                        payCnt <= payCnt + 8'd1;
                    end
                    CHK: begin
                        chkBad <= (byteIn != chkAcc);
                    end
                    default: begin
                    end
                endcase
            end

            if (state == EXEC) begin
                sendIdx   <= 3'd0;
                rspBuf[0] <= RSP_SYNC;
                if (errCode != 8'h00) begin
                    rspBuf[1] <= 8'hFF;
                    rspBuf[2] <= 8'h01;
                    rspBuf[3] <= errCode;
                    rspBuf[4] <= 8'hFE ^ errCode;
                    sendLast  <= 3'd4;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end else begin
                    if (isRead) begin
                        rspBuf[1] <= CMD_READ | 8'h80;
                        rspBuf[2] <= 8'h01;
                        rspBuf[3] <= rdData;
                        rspBuf[4] <= (CMD_READ | 8'h80) ^ 8'h01 ^ rdData;
                        sendLast  <= 3'd4;
                    end else begin
                        // PING and WRITE: empty data field, checksum = RCMD.
                        rspBuf[1] <= cmdReg | 8'h80;
                        rspBuf[2] <= 8'h00;
                        rspBuf[3] <= cmdReg | 8'h80;
                        rspBuf[4] <= 8'h00;
                        sendLast  <= 3'd3;
                    end
                    if (isWrite) begin
                        regFile[pay0[REG_ADDR_W-1:0]] <= pay1;
                    end
                    if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                end
            end

            if ((state == SEND) && rsp_fifo_data_i_rdy && (sendIdx != sendLast)) begin
                sendIdx <= sendIdx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_fifo_data_i_vld = (state == SEND);
    assign rsp_fifo_data_i     = (state == SEND) ? rspBuf[sendIdx] : 8'h00;
    assign busy                = (state != HUNT);
    assign dbgState            = state;

    for (genvar k = 0; k < NUM_REGS; k++) begin : gRegOut
        assign reg_o[8*k +: 8] = regFile[k];
    end

endmodule

// File: tb/tb_cmd_responder.sv
module tb_cmd_responder;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_fifo_empty;
  logic        req_fifo_r_en;
  logic [7:0]  req_fifo_data_o;
  logic        req_fifo_data_o_vld;
  logic [7:0]  rsp_fifo_data_i;
  logic        rsp_fifo_data_i_vld;
  logic        rsp_fifo_data_i_rdy;
  logic [63:0] reg_o;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [2:0]  dbg_state;

  logic [7:0] req_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         pend;
  logic [7:0] pend_data;
  int         checks;
  int         errors;

  cmd_responder #(.REG_ADDR_W(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_fifo_empty      (req_fifo_empty),
    .req_fifo_r_en       (req_fifo_r_en),
    .req_fifo_data_o     (req_fifo_data_o),
    .req_fifo_data_o_vld (req_fifo_data_o_vld),
    .rsp_fifo_data_i     (rsp_fifo_data_i),
    .rsp_fifo_data_i_vld (rsp_fifo_data_i_vld),
    .rsp_fifo_data_i_rdy (rsp_fifo_data_i_rdy),
    .reg_o               (reg_o),
    .busy                (busy),
    .frame_cnt           (frame_cnt),
    .err_cnt             (err_cnt),
    .dbgState            (dbg_state)
  );

  // clock
  initial forever #5 clk = ~clk;

  // request FIFO model and response sink, both acting just after the falling edge
  initial begin
    req_fifo_empty      = 1'b1;
    req_fifo_data_o_vld = 1'b0;
    req_fifo_data_o     = 8'h00;
    pend                = 1'b0;
    pend_data           = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_fifo_data_i_vld && rsp_fifo_data_i_rdy) got_q.push_back(rsp_fifo_data_i);
      req_fifo_data_o_vld = pend;
      req_fifo_data_o     = pend ? pend_data : 8'h00;
      pend                = 1'b0;
      req_fifo_empty      = (req_q.size() == 0);
      #1;
      if (req_fifo_r_en && req_q.size() > 0) begin
        pend      = 1'b1;
        pend_data = req_q.pop_front();
      end
    end
  end

  // driver tasks
  task automatic push_frame(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) req_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic add_exp(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_rsp(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_fifo_data_i_vld !== 1'b0 || rsp_fifo_data_i !== 8'h00) begin
      errors++; $display("FAIL reset_rsp got vld=%b data=%h exp vld=0 data=00", rsp_fifo_data_i_vld, rsp_fifo_data_i);
    end
    checks++;
    if (reg_o !== 64'h0) begin errors++; $display("FAIL reset_reg got %h exp 0", reg_o); end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_busy got busy=%b state=%0d exp 0/0", busy, dbg_state);
    end
    checks++;
    if (frame_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got %h/%h exp 0000/0000", frame_cnt, err_cnt);
    end
    checks++;
    if (req_fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", req_fifo_r_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ping;
    got_q.delete(); exp_q.delete();
    push_frame(4, 64'hA5010001);
    add_exp(4, 64'h5A810081);
    wait_rsp(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ping_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ping_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL ping_cnt got %0d/%0d exp 1/0", frame_cnt, err_cnt);
    end
    checks++;
    if (rsp_fifo_data_i_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ping_idle got vld=%b busy=%b exp 0/0", rsp_fifo_data_i_vld, busy);
    end
  endtask

  task automatic test_write_read;
    got_q.delete(); exp_q.delete();
    push_frame(6, 64'hA50302023C3F);
    add_exp(4, 64'h5A830083);
    wait_rsp(4);
    checks++;
    if (reg_o !== 64'h0000_0000_003C_0000) begin errors++; $display("FAIL write_reg got %h exp 00000000003c0000", reg_o); end
    push_frame(5, 64'hA502010201);
    add_exp(5, 64'h5A82013CBF);
    wait_rsp(9);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wr_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wr_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd3) begin errors++; $display("FAIL wr_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_errors;
    int          rq_n [4] = '{4, 4, 5, 7};
    logic [63:0] rq_v [4] = '{64'hA5010000, 64'hA5070007, 64'hA50201080B, 64'hA503030102_0300};
    logic [63:0] rs_v [4] = '{64'h5AFF0101FF, 64'h5AFF0102FC, 64'h5AFF0104FA, 64'h5AFF0103FD};
    for (int f = 0; f < 4; f++) begin
      got_q.delete(); exp_q.delete();
      push_frame(rq_n[f], rq_v[f]);
      add_exp(5, rs_v[f]);
      wait_rsp(5);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL err%0d_len got %0d exp %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL err%0d_byte%0d got %h exp %h", f, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
      end
      checks++;
      if (err_cnt !== 16'(f + 1) || frame_cnt !== 16'd3) begin
        errors++; $display("FAIL err%0d_cnt got %0d/%0d exp %0d/3", f, err_cnt, frame_cnt, f + 1);
      end
    end
    checks++;
    if (reg_o !== 64'h0000_0000_003C_0000) begin errors++; $display("FAIL err_reg got %h exp 00000000003c0000", reg_o); end
  endtask

  task automatic test_timeout;
    got_q.delete(); exp_q.delete();
    push_frame(4, 64'h00FFA501);
    repeat (TO + 30) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL to_norsp got %0d bytes exp 0", got_q.size()); end
    checks++;
    if (err_cnt !== 16'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL to_cnt got err=%0d busy=%b exp 5/0", err_cnt, busy);
    end
    push_frame(4, 64'hA5010001);
    add_exp(4, 64'h5A810081);
    wait_rsp(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL to_ping_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL to_ping_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd4) begin errors++; $display("FAIL to_frame got %0d exp 4", frame_cnt); end
  endtask

  task automatic test_back_to_back;
    got_q.delete(); exp_q.delete();
    push_frame(4, 64'hA5010001);
    push_frame(5, 64'hA502010201);
    add_exp(4, 64'h5A810081);
    add_exp(5, 64'h5A82013CBF);
    wait_rsp(9);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", frame_cnt); end
  endtask

  task automatic test_backpressure;
    int cyc;
    got_q.delete(); exp_q.delete();
    rsp_fifo_data_i_rdy = 1'b0;
    push_frame(5, 64'hA502010201);
    add_exp(5, 64'h5A82013CBF);
    cyc = 0;
    while (!rsp_fifo_data_i_vld && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rsp_fifo_data_i_vld !== 1'b1 || rsp_fifo_data_i !== 8'h5A) begin
      errors++; $display("FAIL bp_first got vld=%b data=%h exp 1/5a", rsp_fifo_data_i_vld, rsp_fifo_data_i);
    end
    rsp_fifo_data_i_rdy = 1'b1;
    @(negedge clk);
    rsp_fifo_data_i_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_fifo_data_i_vld !== 1'b1 || rsp_fifo_data_i !== 8'h82) begin
        errors++; $display("FAIL bp_stall%0d got vld=%b data=%h exp 1/82", k, rsp_fifo_data_i_vld, rsp_fifo_data_i);
      end
      @(negedge clk);
    end
    rsp_fifo_data_i_rdy = 1'b1;
    wait_rsp(5);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send;
    int cyc;
    got_q.delete(); exp_q.delete();
    push_frame(4, 64'hA5010001);
    cyc = 0;
    while (got_q.size() < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got_q.size() != 2 || rsp_fifo_data_i_vld !== 1'b1) begin
      errors++; $display("FAIL rms_pre got %0d bytes vld=%b exp 2/1", got_q.size(), rsp_fifo_data_i_vld);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (rsp_fifo_data_i_vld !== 1'b0 || rsp_fifo_data_i !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL rms_out got vld=%b data=%h busy=%b exp 0/00/0", rsp_fifo_data_i_vld, rsp_fifo_data_i, busy);
    end
    checks++;
    if (reg_o !== 64'h0 || frame_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      errors++; $display("FAIL rms_state got reg=%h frame=%0d err=%0d exp 0/0/0", reg_o, frame_cnt, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    push_frame(4, 64'hA5010001);
    add_exp(4, 64'h5A810081);
    wait_rsp(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rms_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rms_byte%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rms_cnt got %0d exp 1", frame_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rsp_fifo_data_i_rdy = 1'b1;
    test_reset;
    test_ping;
    test_write_read;
    test_errors;
    test_timeout;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_send;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
